busqueda_binaria_8bits: RTL and testbench
=========================================

# busqueda_binaria_8bits

Sequential binary-search initiator for the 8-bit comparator family: drives a candidate operand onto an external magnitude comparator and consumes its igual/mayor/menor verdicts to locate an unknown 8-bit value. It sits on the operand side of a `Comparador8bits`-style instance (candidate on `a`, unknown on `b`, cascade inputs tied to "equal"). Used for threshold discovery and ADC-style successive approximation.

## Interface
- CON_SIGNO, 0, 0: unsigned search range 0..255; 1: two's-complement range -128..127
- ESPERA, 1, cycles the candidate is held before the verdict is sampled (1..15)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- inicio  input  1  start request, sampled only while idle
- igual_i  input  1  comparator verdict: candidate == unknown
- mayor_i  input  1  comparator verdict: candidate > unknown
- menor_i  input  1  comparator verdict: candidate < unknown
- candidato  output  8  operand driven to the comparator
- ocupado  output  1  search in progress
- listo  output  1  one-cycle completion pulse
- encontrado  output  1  last search ended on igual
- error  output  1  last search hit a non-one-hot verdict
- valor  output  8  result, valid from `listo` until the next accepted `inicio`
- sondeos  output  4  probes used by the last or current search

## Operation
- States: REPOSO, PRESENTA, EVALUA.
- REPOSO: `ocupado` = 0.
  - On `inicio` = 1: lo = minimum, hi = maximum (0/255, or -128/127 when CON_SIGNO = 1).
  - candidato = floor((lo+hi)/2), computed in 10-bit signed arithmetic with an arithmetic shift, so the first probe is 127 unsigned and -1 signed.
  - Clear sondeos, encontrado and error. Go to PRESENTA.
- PRESENTA: hold candidato and count ESPERA cycles, then go to EVALUA.
- EVALUA: sample the verdict and increment sondeos.
  - Exactly igual: valor = candidato, encontrado = 1, finish.
  - Exactly mayor: if candidato == lo, finish not found; else hi = candidato-1.
  - Exactly menor: if candidato == hi, finish not found; else lo = candidato+1.
  - Otherwise (000 or more than one flag set): error = 1, valor = candidato, finish.
  - If the search continues, load the new midpoint into candidato and go to PRESENTA.
- Finish: on the same edge, return to REPOSO and assert `listo` for one cycle. When not found, valor = last candidato.
- The search terminates in at most 9 probes. The sondeos counter never wraps.
- `inicio` while ocupado = 1 is ignored. `inicio` in the `listo` cycle is accepted, because the block is already in REPOSO.
- Verdict inputs are ignored outside EVALUA.

## Timing
- Reset values: state REPOSO, candidato 0, ocupado 0, listo 0, encontrado 0, error 0, valor 0, sondeos 0.
- All outputs are registered.
- Edge E0 accepts `inicio`. After E0: ocupado = 1, candidato = first probe.
- Each probe lasts ESPERA+1 cycles (PRESENTA for ESPERA cycles, then EVALUA for 1).
- With ESPERA = 1, probe k is driven after edge 2(k-1) and sampled at edge 2k.
- Total latency from E0 to `listo` = n·(ESPERA+1) cycles for n probes.
- `listo` and ocupado = 0 appear together after the final evaluation edge.
- Asserting rst_n low mid-search forces reset values immediately (asynchronously). There is no completion pulse, and the next search needs a fresh `inicio`.

## Test plan
- Unsigned, ideal comparator, unknown 100, ESPERA = 1 -> probes 127,63,95,111,103,99,101,100; listo at cycle 16; valor = 100, encontrado = 1, sondeos = 8.
- Unsigned, unknown 255 and then unknown 0 -> 9 probes ending at 255 (listo at cycle 18); 8 probes ending at 0; both encontrado = 1.
- CON_SIGNO = 1, unknown -6 (0xFA) -> probes -1,-65,-33,-17,-9,-5,-7,-6; valor = 0xFA, sondeos = 8.
- Comparator stuck at menor -> probes climb to 255, then finish with encontrado = 0, error = 0, valor = 255, sondeos = 9; stuck at 000 -> error = 1 after 1 probe.
- ESPERA = 3 with a verdict glitch during PRESENTA -> the glitch is ignored; each probe takes 4 cycles; the result is unchanged.
- `inicio` re-pulsed while busy -> ignored. rst_n low at probe 4 -> all outputs 0 immediately, no listo. `inicio` in the listo cycle -> new search starts next cycle.

Source files
------------

// File: rtl/busqueda_binaria_8bits.sv
// Successive-approximation search driving an external magnitude comparator to locate an unknown 8-bit value.
// Latency n*(ESPERA+1) cycles for n probes (n <= 9); no backpressure, inicio is ignored while ocupado.
module busqueda_binaria_8bits #(
    parameter bit          CON_SIGNO = 1'b0,
    parameter int unsigned ESPERA    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    input  logic       igual_i,
    input  logic       mayor_i,
    input  logic       menor_i,
    output logic [7:0] candidato,
    output logic       ocupado,
    output logic       listo,
    output logic       encontrado,
    output logic       error,
    output logic [7:0] valor,
    output logic [3:0] sondeos
);

    typedef enum logic [1:0] {REPOSO, PRESENTA, EVALUA} estado_t;

    // Bounds and candidate are kept 10-bit signed so both ranges share one datapath.
    localparam logic signed [9:0] LIM_MIN   = CON_SIGNO ? -10'sd128 : 10'sd0;
    localparam logic signed [9:0] LIM_MAX   = CON_SIGNO ? 10'sd127 : 10'sd255;
    localparam logic signed [9:0] MID_INI   = (LIM_MIN + LIM_MAX) >>> 1;
    localparam logic [3:0]        ESPERA_M1 = 4'(ESPERA - 1);

    estado_t           r_estado;
    logic signed [9:0] r_lo;
    logic signed [9:0] r_hi;
    logic signed [9:0] r_cand;
    logic [3:0]        r_cnt;
    logic              r_ocupado;
    logic              r_listo;
    logic              r_encontrado;
    logic              r_error;
    logic [7:0]        r_valor;
    logic [3:0]        r_sondeos;

    logic signed [9:0] w_hi_dec;
    logic signed [9:0] w_lo_inc;
    logic signed [9:0] w_mid_mayor;
    logic signed [9:0] w_mid_menor;
    logic [2:0]        w_verd;

    assign w_hi_dec    = r_cand - 10'sd1;
    assign w_lo_inc    = r_cand + 10'sd1;
    assign w_mid_mayor = (r_lo + w_hi_dec) >>> 1;
    assign w_mid_menor = (w_lo_inc + r_hi) >>> 1;
    assign w_verd      = {igual_i, mayor_i, menor_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado     <= REPOSO;
            r_lo         <= '0;
            r_hi         <= '0;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_ocupado    <= 1'b0;
            r_listo      <= 1'b0;
            r_encontrado <= 1'b0;
            r_error      <= 1'b0;
            r_valor      <= '0;
            r_sondeos    <= '0;
        end else begin
            r_listo <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (inicio) begin
                        r_lo         <= LIM_MIN;
                        r_hi         <= LIM_MAX;
                        r_cand       <= MID_INI;
                        r_cnt        <= '0;
                        r_sondeos    <= '0;
                        r_encontrado <= 1'b0;
                        r_error      <= 1'b0;
                        r_ocupado    <= 1'b1;
                        r_estado     <= PRESENTA;
                    end
                end
                PRESENTA: begin
                    if (r_cnt == ESPERA_M1) begin
                        r_cnt    <= '0;
                        r_estado <= EVALUA;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                EVALUA: begin
                    if (r_sondeos != 4'hF) begin
                        r_sondeos <= r_sondeos + 4'd1;
                    end
                    // Default is completion; only a narrowing verdict re-enters PRESENTA.
                    r_valor   <= r_cand[7:0];
                    r_listo   <= 1'b1;
                    r_ocupado <= 1'b0;
                    r_estado  <= REPOSO;
                    case (w_verd)
                        3'b100: r_encontrado <= 1'b1;
                        3'b010: begin
                            if (r_cand != r_lo) begin
                                r_hi      <= w_hi_dec;
                                r_cand    <= w_mid_mayor;
                                r_listo   <= 1'b0;
                                r_ocupado <= 1'b1;
                                r_estado  <= PRESENTA;
                            end
                        end
                        3'b001: begin
                            if (r_cand != r_hi) begin
                                r_lo      <= w_lo_inc;
                                r_cand    <= w_mid_menor;
                                r_listo   <= 1'b0;
                                r_ocupado <= 1'b1;
                                r_estado  <= PRESENTA;
                            end
                        end
                        default: r_error <= 1'b1;
                    endcase
                end
                default: r_estado <= REPOSO;
            endcase
        end
    end

    assign candidato  = r_cand[7:0];
    assign ocupado    = r_ocupado;
    assign listo      = r_listo;
    assign encontrado = r_encontrado;
    assign error      = r_error;
    assign valor      = r_valor;
    assign sondeos    = r_sondeos;

endmodule

// File: tb/tb_busqueda_binaria_8bits.sv
// Bench for busqueda_binaria_8bits: three instances (unsigned/ESPERA=1, signed, ESPERA=3) driven by ideal comparator models.
module tb_busqueda_binaria_8bits;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inicio;
    int         sel;
    logic [1:0] modo;
    logic       glitch;
    logic [7:0] desc [3];

    logic [7:0] cand  [3];
    logic       ocup  [3];
    logic       lst   [3];
    logic       enc   [3];
    logic       err   [3];
    logic [7:0] val   [3];
    logic [3:0] sond  [3];
    logic [2:0] verd  [3];
    logic       ini   [3];

    logic [7:0] q [$];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] comparar(logic [7:0] c, logic [7:0] u, bit sgn, logic [1:0] m, logic g);
        if (g) return 3'b111;
        if (m == 2'd1) return 3'b001;
        if (m == 2'd2) return 3'b000;
        if (c == u) return 3'b100;
        if (sgn ? ($signed(c) > $signed(u)) : (c > u)) return 3'b010;
        return 3'b001;
    endfunction

    assign verd[0] = comparar(cand[0], desc[0], 1'b0, modo, glitch);
    assign verd[1] = comparar(cand[1], desc[1], 1'b1, modo, glitch);
    assign verd[2] = comparar(cand[2], desc[2], 1'b0, modo, glitch);
    assign ini[0]  = inicio && (sel == 0);
    assign ini[1]  = inicio && (sel == 1);
    assign ini[2]  = inicio && (sel == 2);

    busqueda_binaria_8bits #(.CON_SIGNO(1'b0), .ESPERA(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .inicio(ini[0]),
        .igual_i(verd[0][2]), .mayor_i(verd[0][1]), .menor_i(verd[0][0]),
        .candidato(cand[0]), .ocupado(ocup[0]), .listo(lst[0]), .encontrado(enc[0]),
        .error(err[0]), .valor(val[0]), .sondeos(sond[0]));

    busqueda_binaria_8bits #(.CON_SIGNO(1'b1), .ESPERA(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .inicio(ini[1]),
        .igual_i(verd[1][2]), .mayor_i(verd[1][1]), .menor_i(verd[1][0]),
        .candidato(cand[1]), .ocupado(ocup[1]), .listo(lst[1]), .encontrado(enc[1]),
        .error(err[1]), .valor(val[1]), .sondeos(sond[1]));

    busqueda_binaria_8bits #(.CON_SIGNO(1'b0), .ESPERA(3)) u_esp (
        .clk(clk), .rst_n(rst_n), .inicio(ini[2]),
        .igual_i(verd[2][2]), .mayor_i(verd[2][1]), .menor_i(verd[2][0]),
        .candidato(cand[2]), .ocupado(ocup[2]), .listo(lst[2]), .encontrado(enc[2]),
        .error(err[2]), .valor(val[2]), .sondeos(sond[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one search on instance s; expected probes are taken from q in order.
    task automatic buscar(input int s, input int esp, input bit pulse, input bit repulse,
                          input bit glitch_en, input bit chain, input int n,
                          input logic [7:0] v, input logic e, input logic er);
        int cyc;
        logic [7:0] p;
        sel = s;
        if (pulse) begin
            @(negedge clk);
            inicio = 1'b1;
        end
        @(negedge clk);
        inicio = 1'b0;
        chk("ocupado_inicio", ocup[s], 1);
        cyc = 0;
        while (!lst[s] && cyc < 200) begin
            if (cyc % (esp + 1) == 0) begin
                chk("sondeo_esperado", q.size() != 0, 1);
                if (q.size() != 0) begin
                    p = q.pop_front();
                    chk("candidato", cand[s], p);
                end
            end
            glitch = glitch_en && ((cyc % (esp + 1)) != esp);
            if (repulse) inicio = (cyc == 3);
            @(negedge clk);
            cyc++;
        end
        glitch = 1'b0;
        inicio = 1'b0;
        chk("listo", lst[s], 1);
        chk("latencia", cyc, n * (esp + 1));
        chk("ocupado_fin", ocup[s], 0);
        chk("valor", val[s], v);
        chk("encontrado", enc[s], e);
        chk("error", err[s], er);
        chk("sondeos", sond[s], n);
        chk("sondeos_restantes", q.size(), 0);
        q.delete();
        if (chain) begin
            inicio = 1'b1;
        end else begin
            @(negedge clk);
            chk("listo_un_ciclo", lst[s], 0);
        end
    endtask

    initial begin
        bit visto;
        rst_n  = 1'b0;
        inicio = 1'b0;
        modo   = 2'd0;
        glitch = 1'b0;
        sel    = 0;
        desc[0] = 8'd100;
        desc[1] = 8'hFA;
        desc[2] = 8'd100;
        repeat (3) @(negedge clk);
        chk("rst_candidato", cand[0], 0);
        chk("rst_ocupado", ocup[0], 0);
        chk("rst_listo", lst[0], 0);
        chk("rst_encontrado", enc[0], 0);
        chk("rst_error", err[0], 0);
        chk("rst_valor", val[0], 0);
        chk("rst_sondeos", sond[0], 0);
        chk("rst_candidato_sgn", cand[1], 0);
        rst_n = 1'b1;

        q = '{8'd127, 8'd63, 8'd95, 8'd111, 8'd103, 8'd99, 8'd101, 8'd100};
        buscar(0, 1, 1, 0, 0, 0, 8, 8'd100, 1, 0);

        desc[0] = 8'd255;
        q = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
        buscar(0, 1, 1, 0, 0, 0, 9, 8'd255, 1, 0);

        desc[0] = 8'd0;
        q = '{8'd127, 8'd63, 8'd31, 8'd15, 8'd7, 8'd3, 8'd1, 8'd0};
        buscar(0, 1, 1, 0, 0, 0, 8, 8'd0, 1, 0);

        q = '{8'hFF, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hF9, 8'hFA};
        buscar(1, 1, 1, 0, 0, 0, 8, 8'hFA, 1, 0);

        modo = 2'd1;
        q = '{8'd127, 8'd191, 8'd223, 8'd239, 8'd247, 8'd251, 8'd253, 8'd254, 8'd255};
        buscar(0, 1, 1, 0, 0, 0, 9, 8'd255, 0, 0);

        modo = 2'd2;
        q = '{8'd127};
        buscar(0, 1, 1, 0, 0, 0, 1, 8'd127, 0, 1);
        modo = 2'd0;

        q = '{8'd127, 8'd63, 8'd95, 8'd111, 8'd103, 8'd99, 8'd101, 8'd100};
        buscar(2, 3, 1, 0, 1, 0, 8, 8'd100, 1, 0);

        desc[0] = 8'd200;
        q = '{8'd127, 8'd191, 8'd223, 8'd207, 8'd199, 8'd203, 8'd201, 8'd200};
        buscar(0, 1, 1, 1, 0, 0, 8, 8'd200, 1, 0);

        desc[0] = 8'd100;
        q = '{8'd127, 8'd63, 8'd95, 8'd111, 8'd103, 8'd99, 8'd101, 8'd100};
        buscar(0, 1, 1, 0, 0, 1, 8, 8'd100, 1, 0);
        desc[0] = 8'd200;
        q = '{8'd127, 8'd191, 8'd223, 8'd207, 8'd199, 8'd203, 8'd201, 8'd200};
        buscar(0, 1, 0, 0, 0, 0, 8, 8'd200, 1, 0);

        // Abort during probe 4 with an asynchronous reset.
        desc[0] = 8'd100;
        sel = 0;
        @(negedge clk);
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_sondeo4", cand[0], 8'd111);
        rst_n = 1'b0;
        #1;
        chk("abort_candidato", cand[0], 0);
        chk("abort_ocupado", ocup[0], 0);
        chk("abort_listo", lst[0], 0);
        chk("abort_encontrado", enc[0], 0);
        chk("abort_valor", val[0], 0);
        chk("abort_sondeos", sond[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        visto = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (lst[0] || ocup[0]) visto = 1'b1;
        end
        chk("abort_sin_listo", visto, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
